demux13_buf: RTL and testbench
==============================

# demux13_buf

Registered 1:3 router with valid/ready handshake. It is the inverse of the three-input select mux in the datapath. A single producer stream (`in_data`, `in_sel`) is steered to one of three consumer ports (A, B, C), each buffered by a one-entry holding slot. Back-pressure on one consumer never stalls traffic bound for another. It sits between the shared memory/ALU result path and the independent writeback, CSR and debug consumers.

## Interface
- `WIDTH`, default 32: data width of input and all outputs.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input WIDTH: payload from the producer.
- `in_sel` input 2: destination. 00=A, 01=B, 10=C, 11=illegal (drop).
- `in_valid` input 1: producer offers a beat.
- `in_ready` output 1: router accepts the beat this cycle.
- `out_a_data` / `out_b_data` / `out_c_data` output WIDTH: slot payloads.
- `out_a_valid` / `out_b_valid` / `out_c_valid` output 1: slot holds a beat.
- `out_a_ready` / `out_b_ready` / `out_c_ready` input 1: consumer takes the beat.
- `drop_cnt` output 8: dropped-beat counter, present only with the macro (see Configuration).

## Operation
- Each port X has one slot: a `valid_x` flag and a `data_x` register. These drive `out_x_valid` and `out_x_data` directly from flops.
- A port drains when `out_x_valid && out_x_ready`. A beat transfers when `in_valid && in_ready`.
- `in_ready` is combinational from `in_sel`:
  - sel 00/01/10: `in_ready = !valid_x || out_x_ready` for the selected X.
  - sel 11: `in_ready = 1`. The beat is accepted and discarded, and no output changes.
- Slot update for port X each cycle:
  - Fill and drain together: slot stays valid and loads the new data.
  - Fill only: valid set to 1, data loaded.
  - Drain only: valid cleared to 0, data held.
  - Neither: slot holds.
- While `out_x_valid && !out_x_ready`, `out_x_data` is stable.
- The ready of non-selected ports has no effect on `in_ready`. A, B and C drain independently, and more than one may drain in the same cycle.
- `in_sel` and `in_data` are don't-care when `in_valid` is 0. No slot changes except by draining.
- Reset, including mid-transfer: all `valid_x` = 0, all `data_x` = 0, `drop_cnt` = 0. Buffered beats are discarded. After reset `in_ready` = 1 for every sel.

## Timing
- Latency: a beat accepted in cycle N is visible on `out_x_*` in cycle N+1.
- Throughput: 1 beat/cycle sustained to any one port while its consumer holds ready at 1. There are no bubbles on back-to-back beats.
- Combinational paths: `in_sel` → `in_ready`, and `out_x_ready` → `in_ready`. There are no combinational paths from input to output data or valid.
- Reset assertion clears outputs immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Configuration
- `DEMUX13_DROP_CNT_EN`:
  - Defined: `drop_cnt` port is present. It is an 8-bit counter that increments on each accepted beat with sel=11 and saturates at 0xFF.
  - Undefined: the port and counter are absent, and sel=11 beats are silently discarded. Routing behaviour is otherwise identical.

## Structure
- Shared package `demux_pkg`:
  - Localparams `SEL_A=2'b00`, `SEL_B=2'b01`, `SEL_C=2'b10`, `SEL_DROP=2'b11`.
  - Counter width constant `DROP_CNT_W=8`.
- Sub-module `demux_slot`: one-entry buffer, instantiated three times.
  - Ports: `clk`, `rst`, `fill`, `fill_data`, `out_data`, `out_valid`, `out_ready`, and `can_accept`.
  - `can_accept = !valid || out_ready`.
- The top level holds the sel decode, the `in_ready` mux and the optional counter.

## Test plan
- Reset: assert `rst` with all slots full. All `out_x_valid` go to 0 and all data to 0 without a clock edge. `in_ready` = 1 for each sel.
- Single route: sel=01, data 0xDEADBEEF, valid for 1 cycle, `out_b_ready`=1. Next cycle `out_b_valid`=1 and `out_b_data`=0xDEADBEEF; A and C stay invalid. Following cycle `out_b_valid`=0.
- Back-to-back: sel=00, data 0x1, 0x2, 0x3 on consecutive cycles, `out_a_ready`=1. A outputs 0x1, 0x2, 0x3 on consecutive cycles and `in_ready` stays 1 throughout.
- Back-pressure isolation:
  - Hold `out_a_ready`=0 and send 0x10 to A. The next beat to A sees `in_ready`=0.
  - A beat 0x20 to C is still accepted and appears on C.
  - Raising `out_a_ready` drains 0x10 and accepts the pending A beat the same cycle.
- Drop: sel=11, data 0x55, valid. `in_ready`=1 and no `out_x_valid` rises. With the macro, `drop_cnt` goes 0→1. 300 drops leave it at 0xFF.
- Mid-operation reset: fill B, then pulse `rst` while `out_b_ready`=0. `out_b_valid`=0 after reset, and a fresh beat to B is accepted immediately.

Source files
------------

// File: rtl/demux_pkg.sv
// demux13_buf shared constants: destination select codes and the
// width of the optional dropped-beat counter.
package demux_pkg;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding buffer for one router output port.
// Ports: clk, rst (async, active-high), fill/fill_data (load a beat),
// out_data/out_valid/out_ready (consumer side), can_accept (slot
// free this cycle, counting a same-cycle drain).
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             can_accept
);

  logic drain;

  assign drain      = out_valid && out_ready;
  assign can_accept = !out_valid || out_ready;

  // A fill wins over a drain: the slot stays valid with new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fill) begin
      out_valid <= 1'b1;
      out_data  <= fill_data;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux13_buf.sv
// demux13_buf: registered 1:3 router, valid/ready on every port.
// Ports: clk, rst (async, active-high); in_data/in_sel/in_valid/
// in_ready from the producer; out_{a,b,c}_{data,valid,ready} to the
// three consumers. With DEMUX13_DROP_CNT_EN defined, drop_cnt
// counts accepted sel=11 beats, saturating at 0xFF.
module demux13_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [WIDTH-1:0] out_c_data,
  output logic             out_c_valid,
  input  logic             out_c_ready
`ifdef DEMUX13_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic can_a;
  logic can_b;
  logic can_c;
  logic xfer;
  logic fill_a;
  logic fill_b;
  logic fill_c;

  // Only the selected port's slot gates the producer, so a stalled
  // consumer never blocks beats bound elsewhere.
  always_comb begin
    in_ready = 1'b1;
    unique case (in_sel)
      SEL_A:    in_ready = can_a;
      SEL_B:    in_ready = can_b;
      SEL_C:    in_ready = can_c;
      SEL_DROP: in_ready = 1'b1;
    endcase
  end

  assign xfer   = in_valid && in_ready;
  assign fill_a = xfer && (in_sel == SEL_A);
  assign fill_b = xfer && (in_sel == SEL_B);
  assign fill_c = xfer && (in_sel == SEL_C);

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk        (clk),
    .rst        (rst),
    .fill       (fill_a),
    .fill_data  (in_data),
    .out_data   (out_a_data),
    .out_valid  (out_a_valid),
    .out_ready  (out_a_ready),
    .can_accept (can_a)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk        (clk),
    .rst        (rst),
    .fill       (fill_b),
    .fill_data  (in_data),
    .out_data   (out_b_data),
    .out_valid  (out_b_valid),
    .out_ready  (out_b_ready),
    .can_accept (can_b)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_c (
    .clk        (clk),
    .rst        (rst),
    .fill       (fill_c),
    .fill_data  (in_data),
    .out_data   (out_c_data),
    .out_valid  (out_c_valid),
    .out_ready  (out_c_ready),
    .can_accept (can_c)
  );

`ifdef DEMUX13_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (xfer && (in_sel == SEL_DROP) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux13_buf.sv
// Bench for demux13_buf: occupancy model of the three slots plus
// directed vectors with literal expectations.
module tb_demux13_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_a_data, out_b_data, out_c_data;
  logic        out_a_valid, out_b_valid, out_c_valid;
  logic        out_a_ready = 1'b0;
  logic        out_b_ready = 1'b0;
  logic        out_c_ready = 1'b0;
`ifdef DEMUX13_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  demux13_buf #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .out_c_data  (out_c_data),
    .out_c_valid (out_c_valid),
    .out_c_ready (out_c_ready)
`ifdef DEMUX13_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each port is a queue of capacity one (occupancy + payload).
  int          m_cnt[3];
  logic [31:0] m_dat[3];
  int          m_drop;

  function automatic bit port_rdy(input int p);
    case (p)
      0:       return out_a_ready;
      1:       return out_b_ready;
      default: return out_c_ready;
    endcase
  endfunction

  function automatic bit exp_in_ready();
    if (in_sel == 2'd3) return 1'b1;
    return (m_cnt[int'(in_sel)] == 0) || port_rdy(int'(in_sel));
  endfunction

  initial begin
    for (int p = 0; p < 3; p++) begin
      m_cnt[p] = 0;
      m_dat[p] = '0;
    end
    m_drop = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int p = 0; p < 3; p++) begin
          m_cnt[p] = 0;
          m_dat[p] = '0;
        end
        m_drop = 0;
      end else begin
        bit acc;
        acc = in_valid && exp_in_ready();
        if (acc && in_sel == 2'd3 && m_drop < 255) m_drop++;
        for (int p = 0; p < 3; p++) begin
          if (m_cnt[p] > 0 && port_rdy(p)) m_cnt[p]--;
          if (acc && int'(in_sel) == p) begin
            m_cnt[p]++;
            m_dat[p] = in_data;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_a_valid", 32'(out_a_valid), 32'(m_cnt[0] > 0));
    chk("m_b_valid", 32'(out_b_valid), 32'(m_cnt[1] > 0));
    chk("m_c_valid", 32'(out_c_valid), 32'(m_cnt[2] > 0));
    chk("m_a_data", out_a_data, m_dat[0]);
    chk("m_b_data", out_b_data, m_dat[1]);
    chk("m_c_data", out_c_data, m_dat[2]);
    chk("m_in_ready", 32'(in_ready), 32'(exp_in_ready()));
`ifdef DEMUX13_DROP_CNT_EN
    chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] d);
    in_sel = s;
    in_data = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;

    // Fill all slots, then reset asynchronously mid-cycle.
    send(2'd0, 32'h11);
    send(2'd1, 32'h22);
    send(2'd2, 32'h33);
    chk("full_a", 32'(out_a_valid), 32'd1);
    chk("full_c_data", out_c_data, 32'h33);
    #2 rst = 1'b1;
    #1;
    chk("rst_a_valid", 32'(out_a_valid), 32'd0);
    chk("rst_b_valid", 32'(out_b_valid), 32'd0);
    chk("rst_c_valid", 32'(out_c_valid), 32'd0);
    chk("rst_a_data", out_a_data, 32'd0);
    chk("rst_b_data", out_b_data, 32'd0);
    chk("rst_c_data", out_c_data, 32'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    end
    step();
    rst = 1'b0;
`ifdef DEMUX13_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Single route to B.
    out_b_ready = 1'b1;
    send(2'd1, 32'hDEADBEEF);
    chk("route_b_valid", 32'(out_b_valid), 32'd1);
    chk("route_b_data", out_b_data, 32'hDEADBEEF);
    chk("route_a_valid", 32'(out_a_valid), 32'd0);
    chk("route_c_valid", 32'(out_c_valid), 32'd0);
    step();
    chk("route_b_gone", 32'(out_b_valid), 32'd0);

    // Back-to-back to A with ready held high.
    out_a_ready = 1'b1;
    in_sel = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'(i);
      in_valid = 1'b1;
      #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("b2b_a_valid", 32'(out_a_valid), 32'd1);
      chk("b2b_a_data", out_a_data, 32'(i));
    end
    in_valid = 1'b0;
    step();

    // Back-pressure on A does not block C.
    out_a_ready = 1'b0;
    out_c_ready = 1'b1;
    send(2'd0, 32'h10);
    in_sel = 2'd0;
    in_data = 32'h99;
    in_valid = 1'b1;
    #1 chk("bp_a_blocked", 32'(in_ready), 32'd0);
    step();
    in_sel = 2'd2;
    in_data = 32'h20;
    #1 chk("bp_c_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_c_data", out_c_data, 32'h20);
    chk("bp_c_valid", 32'(out_c_valid), 32'd1);
    chk("bp_a_held", out_a_data, 32'h10);
    in_sel = 2'd0;
    in_data = 32'h30;
    out_a_ready = 1'b1;
    #1 chk("bp_a_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_a_new", out_a_data, 32'h30);
    chk("bp_a_valid", 32'(out_a_valid), 32'd1);
    step();

    // Drops.
    in_sel = 2'd3;
    in_data = 32'h55;
    in_valid = 1'b1;
    #1 chk("drop_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("drop_no_a", 32'(out_a_valid), 32'd0);
    chk("drop_no_b", 32'(out_b_valid), 32'd0);
    chk("drop_no_c", 32'(out_c_valid), 32'd0);
`ifdef DEMUX13_DROP_CNT_EN
    chk("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    chk("drops_no_b", 32'(out_b_valid), 32'd0);
`ifdef DEMUX13_DROP_CNT_EN
    chk("drop_cnt_sat", 32'(drop_cnt), 32'hFF);
`endif

    // Mid-operation reset with B stalled.
    out_b_ready = 1'b0;
    send(2'd1, 32'h77);
    chk("mid_b_full", 32'(out_b_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk("mid_b_cleared", 32'(out_b_valid), 32'd0);
    step();
    rst = 1'b0;
    in_sel = 2'd1;
    in_data = 32'h88;
    in_valid = 1'b1;
    #1 chk("mid_b_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("mid_b_data", out_b_data, 32'h88);
    chk("mid_b_valid", 32'(out_b_valid), 32'd1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
